// File: rtl/sram16_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : sram16_resp_if
// Description : CPU data-port bus and 16-bit asynchronous SRAM pins served
//               by sram16_resp. master = CPU/board side, slave = responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram16_resp_if #(
  parameter int ADDR_W = 18
);
  // CPU data port
  logic [23:0]       adr;
  logic              rd;
  logic              wr;
  logic              ben;
  logic [31:0]       outbus;
  logic [31:0]       inbus;
  logic              memwait;
  // SRAM pins
  logic [ADDR_W-1:0] sram_a;
  logic [15:0]       sram_d_o;
  logic [15:0]       sram_d_i;
  logic              sram_d_oe;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic              sram_ub_n;
  logic              sram_lb_n;

  modport master (
    output adr, rd, wr, ben, outbus, sram_d_i,
    input  inbus, memwait, sram_a, sram_d_o, sram_d_oe,
           sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );

  modport slave (
    input  adr, rd, wr, ben, outbus, sram_d_i,
    output inbus, memwait, sram_a, sram_d_o, sram_d_oe,
           sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );
endinterface
`default_nettype wire

// File: rtl/sram16_resp.sv
`default_nettype none
// ============================================================================
// Module      : sram16_resp
// Description : CPU data-port responder on a 16-bit asynchronous SRAM. Each
//               32-bit word is split into two halfword phases; bytes take one
//               phase. memwait freezes the CPU while the SRAM is busy.
// Revision    : 1.0 - initial release
// ============================================================================
module sram16_resp #(
  parameter int WAIT   = 1,
  parameter int ADDR_W = 18
) (
  input  logic         clk,
  input  logic         rst,
  sram16_resp_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] c_wait = 4'(WAIT);

  state_t            r_state;
  state_t            w_state_nx;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nx;

  // Request latched at acceptance
  logic [ADDR_W:0]   r_adr;
  logic              r_ben;
  logic              r_wr;
  logic [31:0]       r_dat;
  logic [15:0]       r_lo;

  logic              w_req;
  logic              w_phase_end;
  logic [ADDR_W:0]   w_adr;
  logic              w_ben;
  logic              w_wr;
  logic [31:0]       w_dat;
  logic              w_active;
  logic              w_half;
  logic [ADDR_W-1:0] w_a_nx;
  logic [15:0]       w_d_nx;

  // Accept only outside the I/O region (top 64 bytes of the address space)
  assign w_req       = (bus.rd | bus.wr) && (bus.adr[23:6] != 18'h3FFFF);
  assign w_phase_end = (r_cnt == c_wait);

  // In IDLE the first phase is set up straight from the CPU inputs so that
  // the SRAM pins are registered ready for the first LO cycle.
  assign w_adr = (r_state == S_IDLE) ? bus.adr[ADDR_W:0]      : r_adr;
  assign w_ben = (r_state == S_IDLE) ? bus.ben                : r_ben;
  assign w_wr  = (r_state == S_IDLE) ? (bus.wr & ~bus.rd)     : r_wr;
  assign w_dat = (r_state == S_IDLE) ? bus.outbus             : r_dat;

  // Next state and phase counter
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nx = S_LO;
          w_cnt_nx   = 4'd0;
        end
      end
      S_LO: begin
        if (w_phase_end) begin
          w_state_nx = r_ben ? S_DONE : S_HI;
          w_cnt_nx   = 4'd0;
        end else begin
          w_cnt_nx   = r_cnt + 4'd1;
        end
      end
      S_HI: begin
        if (w_phase_end) begin
          w_state_nx = S_DONE;
          w_cnt_nx   = 4'd0;
        end else begin
          w_cnt_nx   = r_cnt + 4'd1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Pin values for the coming cycle; bytes pick the halfword from adr[1]
  assign w_active = (w_state_nx == S_LO) || (w_state_nx == S_HI);
  assign w_half   = w_ben ? w_adr[1] : (w_state_nx == S_HI);
  assign w_a_nx   = {w_adr[ADDR_W:2], w_half};
  assign w_d_nx   = w_half ? w_dat[31:16] : w_dat[15:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Request latch, registered SRAM strobes and load data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_adr         <= '0;
      r_ben         <= 1'b0;
      r_wr          <= 1'b0;
      r_dat         <= 32'd0;
      r_lo          <= 16'd0;
      bus.inbus     <= 32'd0;
      bus.memwait   <= 1'b0;
      bus.sram_a    <= '0;
      bus.sram_d_o  <= 16'd0;
      bus.sram_d_oe <= 1'b0;
      bus.sram_ce_n <= 1'b1;
      bus.sram_oe_n <= 1'b1;
      bus.sram_we_n <= 1'b1;
      bus.sram_ub_n <= 1'b1;
      bus.sram_lb_n <= 1'b1;
    end else begin
      if (r_state == S_IDLE && w_req) begin
        r_adr <= w_adr;
        r_ben <= w_ben;
        r_wr  <= w_wr;
        r_dat <= w_dat;
      end
      bus.memwait   <= w_active;
      bus.sram_ce_n <= ~w_active;
      bus.sram_oe_n <= ~(w_active & ~w_wr);
      // First cycle of a write phase is address setup with we_n high
      bus.sram_we_n <= ~(w_active & w_wr & (w_cnt_nx != 4'd0));
      bus.sram_d_oe <= w_active & w_wr;
      bus.sram_ub_n <= ~w_active | (w_ben & ~w_adr[0]);
      bus.sram_lb_n <= ~w_active | (w_ben &  w_adr[0]);
      if (w_active) begin
        bus.sram_a <= w_a_nx;
      end
      if (w_active && w_wr) begin
        bus.sram_d_o <= w_d_nx;
      end
      // Read data is taken at the edge closing each read phase
      if (r_state == S_LO && w_phase_end && !r_wr) begin
        if (r_ben) begin
          bus.inbus <= {bus.sram_d_i, bus.sram_d_i};
        end else begin
          r_lo <= bus.sram_d_i;
        end
      end
      if (r_state == S_HI && w_phase_end && !r_wr) begin
        bus.inbus <= {bus.sram_d_i, r_lo};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram16_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram16_resp
// Description : Directed self-checking bench for sram16_resp: a WAIT=1
//               instance on a behavioural SRAM and a WAIT=3 instance on an
//               address-pattern SRAM for the reset-abort case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram16_resp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sram16_resp_if #(.ADDR_W(18)) bus1 ();
  sram16_resp_if #(.ADDR_W(18)) bus2 ();

  sram16_resp #(.WAIT(1), .ADDR_W(18)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  sram16_resp #(.WAIT(3), .ADDR_W(18)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  // Behavioural SRAM for instance 1 (256 halfwords, byte lanes)
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (!bus1.sram_ce_n && !bus1.sram_we_n) begin
      if (!bus1.sram_lb_n) mem[bus1.sram_a[7:0]][7:0]  <= bus1.sram_d_o[7:0];
      if (!bus1.sram_ub_n) mem[bus1.sram_a[7:0]][15:8] <= bus1.sram_d_o[15:8];
    end
  end
  assign bus1.sram_d_i = mem[bus1.sram_a[7:0]];

  // Instance 2 reads a pattern derived from the address
  assign bus2.sram_d_i = {8'hC3, bus2.sram_a[7:0]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] strb1();
    return {bus1.sram_ce_n, bus1.sram_oe_n, bus1.sram_we_n, bus1.sram_ub_n, bus1.sram_lb_n};
  endfunction

  function automatic logic [4:0] strb2();
    return {bus2.sram_ce_n, bus2.sram_oe_n, bus2.sram_we_n, bus2.sram_ub_n, bus2.sram_lb_n};
  endfunction

  // Per-cycle pin check on instance 1
  task automatic pins(input string tag, input logic mw, input logic [17:0] a,
                      input logic [15:0] d, input logic [4:0] s, input logic oe);
    chk({tag, ".memwait"}, 32'(bus1.memwait), 32'(mw));
    chk({tag, ".sram_a"},  32'(bus1.sram_a), 32'(a));
    chk({tag, ".d_o"},     32'(bus1.sram_d_o), 32'(d));
    chk({tag, ".strobes"}, 32'(strb1()), 32'(s));
    chk({tag, ".d_oe"},    32'(bus1.sram_d_oe), 32'(oe));
  endtask

  // Issue one access on instance 1, count memwait cycles, return DONE data
  task automatic access(input logic is_rd, input logic [23:0] a, input logic b,
                        input logic [31:0] d, output int cnt, output logic [31:0] data);
    bus1.rd = is_rd; bus1.wr = ~is_rd; bus1.adr = a; bus1.ben = b; bus1.outbus = d;
    tick();
    bus1.rd = 1'b0; bus1.wr = 1'b0;
    cnt = 0;
    while (bus1.memwait === 1'b1 && cnt < 64) begin
      cnt++;
      tick();
    end
    data = bus1.inbus;
    tick();
  endtask

  int          n;
  logic [31:0] dat;

  initial begin
    bus1.rd = 0; bus1.wr = 0; bus1.ben = 0; bus1.adr = 0; bus1.outbus = 0;
    bus2.rd = 0; bus2.wr = 0; bus2.ben = 0; bus2.adr = 0; bus2.outbus = 0;
    tick(); tick();

    // Reset values while rst is held
    pins("reset", 1'b0, 18'h0, 16'h0, 5'h1F, 1'b0);
    chk("reset.inbus", bus1.inbus, 32'h0);
    rst = 1'b0;
    tick();

    // Word store 0x12345678 at 0x000100
    bus1.wr = 1; bus1.adr = 24'h000100; bus1.ben = 0; bus1.outbus = 32'h12345678;
    tick();
    bus1.wr = 0;
    pins("wst.c1", 1'b1, 18'h00080, 16'h5678, 5'h0C, 1'b1); tick();
    pins("wst.c2", 1'b1, 18'h00080, 16'h5678, 5'h08, 1'b1); tick();
    pins("wst.c3", 1'b1, 18'h00081, 16'h1234, 5'h0C, 1'b1); tick();
    pins("wst.c4", 1'b1, 18'h00081, 16'h1234, 5'h08, 1'b1); tick();
    pins("wst.done", 1'b0, 18'h00081, 16'h1234, 5'h1F, 1'b0); tick();

    // Word load back
    access(1'b1, 24'h000100, 1'b0, 32'h0, n, dat);
    chk("wld.cycles", 32'(n), 32'd4);
    chk("wld.inbus", dat, 32'h12345678);

    // Byte store 0xAB into byte 3 of the word
    bus1.wr = 1; bus1.adr = 24'h000103; bus1.ben = 1; bus1.outbus = 32'hAB000000;
    tick();
    bus1.wr = 0;
    pins("bst.c1", 1'b1, 18'h00081, 16'hAB00, 5'h0D, 1'b1); tick();
    pins("bst.c2", 1'b1, 18'h00081, 16'hAB00, 5'h09, 1'b1); tick();
    pins("bst.done", 1'b0, 18'h00081, 16'hAB00, 5'h1F, 1'b0); tick();

    // Word load after byte store, issued back-to-back with the next access
    access(1'b1, 24'h000100, 1'b0, 32'h0, n, dat);
    chk("wld2.cycles", 32'(n), 32'd4);
    chk("wld2.inbus", dat, 32'hAB345678);

    // Byte load of halfword 1
    access(1'b1, 24'h000102, 1'b1, 32'h0, n, dat);
    chk("bld.cycles", 32'(n), 32'd2);
    chk("bld.inbus", dat, 32'hAB34AB34);

    // I/O region is ignored
    bus1.rd = 1; bus1.adr = 24'hFFFFC4; bus1.ben = 0;
    tick();
    bus1.rd = 0;
    for (int i = 0; i < 3; i++) begin
      chk("io.memwait", 32'(bus1.memwait), 32'd0);
      chk("io.strobes", 32'(strb1()), 32'h1F);
      tick();
    end
    chk("io.inbus", bus1.inbus, 32'hAB34AB34);

    // Block still idle: immediate byte load of halfword 0
    access(1'b1, 24'h000101, 1'b1, 32'h0, n, dat);
    chk("bld0.cycles", 32'(n), 32'd2);
    chk("bld0.inbus", dat, 32'h56785678);

    // WAIT=3 word load aborted by reset during HI
    bus2.rd = 1; bus2.adr = 24'h000200; bus2.ben = 0;
    tick();
    bus2.rd = 0;
    chk("rst2.lo.memwait", 32'(bus2.memwait), 32'd1);
    chk("rst2.lo.sram_a", 32'(bus2.sram_a), 32'h00100);
    tick(); tick(); tick(); tick(); tick();
    chk("rst2.hi.memwait", 32'(bus2.memwait), 32'd1);
    chk("rst2.hi.sram_a", 32'(bus2.sram_a), 32'h00101);
    chk("rst2.hi.strobes", 32'(strb2()), 32'h04);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2.memwait", 32'(bus2.memwait), 32'd0);
    chk("rst2.strobes", 32'(strb2()), 32'h1F);
    chk("rst2.inbus", bus2.inbus, 32'h0);
    tick();
    tick();
    bus2.rd = 1; bus2.adr = 24'h000200; bus2.ben = 0;
    tick();
    bus2.rd = 0;
    n = 0;
    while (bus2.memwait === 1'b1 && n < 64) begin
      n++;
      tick();
    end
    chk("rst2.new.cycles", 32'(n), 32'd8);
    chk("rst2.new.inbus", bus2.inbus, 32'hC301C300);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
